// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the per-source TX FIFOs, the round-robin arbiter and the UART transmitter.
// Handshake: a byte moves on a rising clk edge only when its valid and ready are both high. A source holds valid
// (and its data/last) until it is accepted. Ready may depend combinationally on valid, but valid never depends on ready.
interface uart_tx_arbiter_if #(
  parameter int NumReq = 4
);
  localparam int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumReq-1:0]   reqValid;
  logic [NumReq-1:0]   reqLast;
  logic [NumReq*8-1:0] reqData;
  logic [NumReq-1:0]   reqReady;
  logic                txValid;
  logic [7:0]          txData;
  logic                txReady;
  logic                grantValid;
  logic [IdWidth-1:0]  grantId;
  logic                timeoutErr;

  // master: the sources plus the transmitter (the side that surrounds the arbiter)
  modport master (
    output reqValid, reqLast, reqData, txReady,
    input  reqReady, txValid, txData, grantValid, grantId, timeoutErr
  );

  // slave: the arbiter itself
  modport slave (
    input  reqValid, reqLast, reqData, txReady,
    output reqReady, txValid, txData, grantValid, grantId, timeoutErr
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking that shares one UART TX byte path among NumReq sources.
// Optional UART_ARB_BURST_LIMIT_EN caps each grant at MaxBurst bytes, so long packets may be split.
module uart_tx_arbiter #(
  parameter  int NumReq      = 4,
  parameter  int IdleTimeout = 64,
  parameter  int MaxBurst    = 16,
  localparam int IdWidth     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               syncReset,
  uart_tx_arbiter_if.slave   bus,
  output logic               dbg_state,
  output logic [IdWidth-1:0] dbg_rr_ptr
);

  localparam int IdleW = $clog2(IdleTimeout) + 1;

  if (NumReq < 2 || NumReq > 16 || IdleTimeout < 2 || MaxBurst < 1) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  state_t             state, state_next;
  logic [IdWidth-1:0] rr_ptr, grant_id, winner, next_ptr;
  logic [IdleW-1:0]   idle_cnt;
  logic               timeout_err;
  logic               any_valid, cur_valid, cur_last, xfer, timeout, burst_hit, grant_release;
  int                 idx;

  assign any_valid = |bus.reqValid;
  assign cur_valid = bus.reqValid[grant_id];
  assign cur_last  = bus.reqLast[grant_id];
  assign xfer      = (state == S_LOCK) && cur_valid && bus.txReady;
  assign timeout   = (state == S_LOCK) && !cur_valid && (idle_cnt == IdleW'(IdleTimeout - 1));
  assign next_ptr  = (grant_id == IdWidth'(NumReq - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_BURST_LIMIT_EN
  localparam int BurstW = $clog2(MaxBurst) + 1;
  logic [BurstW-1:0] burst_cnt;

  assign burst_hit = xfer && (burst_cnt == BurstW'(MaxBurst - 1));

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      burst_cnt <= '0;
    end else if (syncReset || state == S_IDLE) begin
      burst_cnt <= '0;
    end else if (xfer) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  assign burst_hit = 1'b0;
`endif

  assign grant_release = (xfer && (cur_last || burst_hit)) || timeout;

  // Upward search from rr_ptr with explicit wrap, so non-power-of-2 NumReq never visits a phantom index.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (bus.reqValid[idx]) winner = IdWidth'(idx);
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
    end else if (syncReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (any_valid) state_next = S_LOCK;
      S_LOCK: if (grant_release) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      grant_id    <= '0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (syncReset) begin
      grant_id    <= '0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout;
      if (state == S_IDLE && any_valid) grant_id <= winner;
      if (state == S_LOCK && grant_release) rr_ptr <= next_ptr;
      // Only a granted requester with valid low is idle; backpressure keeps the counter at zero.
      if (state == S_IDLE || grant_release || cur_valid) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus.reqReady   = '0;
    bus.txValid    = 1'b0;
    bus.txData     = 8'h00;
    bus.grantValid = 1'b0;
    if (state == S_LOCK) begin
      bus.reqReady[grant_id] = bus.txReady;
      bus.txValid            = cur_valid;
      bus.txData             = bus.reqData[int'(grant_id)*8 +: 8];
      bus.grantValid         = 1'b1;
    end
  end

  assign bus.grantId    = grant_id;
  assign bus.timeoutErr = timeout_err;
  assign dbg_state      = (state == S_LOCK);
  assign dbg_rr_ptr     = rr_ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single packet, rotation, idle timeout, backpressure,
// mid-packet reset and long-packet streaming (split into bursts when UART_ARB_BURST_LIMIT_EN is set).
module tb_uart_tx_arbiter;

  localparam int NumReq = 4;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       syncReset = 1'b0;
  logic       dbg_state;
  logic [1:0] dbg_rr_ptr;
  int         checks = 0;
  int         failures = 0;
  int         xfer_cnt = 0;

  uart_tx_arbiter_if #(.NumReq(NumReq)) bus ();

  uart_tx_arbiter #(.NumReq(NumReq), .IdleTimeout(64), .MaxBurst(4)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .syncReset  (syncReset),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.txValid && bus.txReady) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int base;
    int rem0, rem1;
    bit prev_gv;
    logic [7:0] exp_q[$];
    logic [7:0] got_id_q[$];
    logic [7:0] got_len_q[$];
    logic [7:0] exp_len_q[$];

    bus.reqValid = '0;
    bus.reqLast  = '0;
    bus.reqData  = '0;
    bus.txReady  = 1'b1;

    // reset values
    #1;
    chk("rst_grant_valid", 32'(bus.grantValid), 0);
    chk("rst_tx_valid",    32'(bus.txValid), 0);
    chk("rst_tx_data",     32'(bus.txData), 0);
    chk("rst_req_ready",   32'(bus.reqReady), 0);
    chk("rst_timeout",     32'(bus.timeoutErr), 0);
    chk("rst_grant_id",    32'(bus.grantId), 0);
    chk("rst_rr_ptr",      32'(dbg_rr_ptr), 0);
    #3 nReset = 1'b1;

    // single 3-byte packet on requester 2
    tick();
    bus.reqValid = 4'b0100;
    bus.reqData  = 32'h00A1_0000;
    #1;
    chk("p1_idle_gv", 32'(bus.grantValid), 0);
    chk("p1_idle_txv", 32'(bus.txValid), 0);
    tick();
    #1;
    chk("p1_gv", 32'(bus.grantValid), 1);
    chk("p1_gid", 32'(bus.grantId), 2);
    chk("p1_rdy", 32'(bus.reqReady), 32'b0100);
    chk("p1_a1", 32'(bus.txData), 32'hA1);
    tick();
    bus.reqData = 32'h00A2_0000;
    #1;
    chk("p1_a2", 32'(bus.txData), 32'hA2);
    chk("p1_gid2", 32'(bus.grantId), 2);
    tick();
    bus.reqData = 32'h00A3_0000;
    bus.reqLast = 4'b0100;
    #1;
    chk("p1_a3", 32'(bus.txData), 32'hA3);
    tick();
    bus.reqValid = '0;
    bus.reqLast  = '0;
    #1;
    chk("p1_release", 32'(bus.grantValid), 0);
    chk("p1_rr", 32'(dbg_rr_ptr), 3);
    chk("p1_count", 32'(xfer_cnt), 3);

    // synchronous reset then rotation with all requesters busy
    tick();
    syncReset = 1'b1;
    tick();
    syncReset = 1'b0;
    #1;
    chk("srst_rr", 32'(dbg_rr_ptr), 0);
    chk("srst_gv", 32'(bus.grantValid), 0);
    bus.reqValid = 4'hF;
    bus.reqLast  = 4'hF;
    bus.reqData  = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("rot_gv", 32'(bus.grantValid), 1);
      chk("rot_gid", 32'(bus.grantId), 32'(k % 4));
      chk("rot_data", 32'(bus.txData), 32'h10 + 32'(k % 4));
      tick();
      #1;
      chk("rot_gap", 32'(bus.grantValid), 0);
    end
    bus.reqValid = '0;
    bus.reqLast  = '0;

    // idle timeout on requester 1
    tick();
    chk("to_rr_start", 32'(dbg_rr_ptr), 1);
    bus.reqValid = 4'b0010;
    bus.reqData  = 32'h0000_5500;
    base = xfer_cnt;
    tick();
    #1;
    chk("to_gid", 32'(bus.grantId), 1);
    chk("to_data", 32'(bus.txData), 32'h55);
    tick();
    bus.reqValid = '0;
    #1;
    chk("to_one_byte", 32'(xfer_cnt), 32'(base + 1));
    chk("to_held", 32'(bus.grantValid), 1);
    for (int k = 1; k < 64; k++) begin
      tick();
      #1;
      chk("to_no_pulse", 32'(bus.timeoutErr), 0);
      chk("to_still_held", 32'(bus.grantValid), 1);
    end
    tick();
    #1;
    chk("to_pulse", 32'(bus.timeoutErr), 1);
    chk("to_released", 32'(bus.grantValid), 0);
    tick();
    #1;
    chk("to_pulse_end", 32'(bus.timeoutErr), 0);
    chk("to_no_dup", 32'(xfer_cnt), 32'(base + 1));
    chk("to_rr", 32'(dbg_rr_ptr), 2);

    // long backpressure on requester 0 must not time out
    bus.reqValid = 4'b0001;
    bus.reqLast  = 4'b0001;
    bus.reqData  = 32'h0000_0077;
    bus.txReady  = 1'b0;
    base = xfer_cnt;
    tick();
    #1;
    chk("bp_gid", 32'(bus.grantId), 0);
    for (int k = 0; k < 200; k++) begin
      chk("bp_rdy", 32'(bus.reqReady), 0);
      chk("bp_no_to", 32'(bus.timeoutErr), 0);
      chk("bp_gv", 32'(bus.grantValid), 1);
      tick();
    end
    bus.txReady = 1'b1;
    #1;
    chk("bp_rdy_on", 32'(bus.reqReady), 32'b0001);
    chk("bp_data", 32'(bus.txData), 32'h77);
    tick();
    bus.reqValid = '0;
    bus.reqLast  = '0;
    #1;
    chk("bp_release", 32'(bus.grantValid), 0);
    chk("bp_count", 32'(xfer_cnt), 32'(base + 1));
    chk("bp_rr", 32'(dbg_rr_ptr), 1);

    // asynchronous reset in the middle of a packet on requester 3
    bus.reqValid = 4'b1000;
    bus.reqData  = 32'h3300_0000;
    tick();
    #1;
    chk("ar_gid", 32'(bus.grantId), 3);
    tick();
    nReset = 1'b0;
    #1;
    chk("ar_gv", 32'(bus.grantValid), 0);
    chk("ar_txv", 32'(bus.txValid), 0);
    chk("ar_txd", 32'(bus.txData), 0);
    chk("ar_rdy", 32'(bus.reqReady), 0);
    chk("ar_gid0", 32'(bus.grantId), 0);
    chk("ar_rr0", 32'(dbg_rr_ptr), 0);
    #1 nReset = 1'b1;
    tick();
    #1;
    chk("ar_regrant", 32'(bus.grantValid), 1);
    chk("ar_regrant_id", 32'(bus.grantId), 3);
    bus.reqLast = 4'b1000;
    tick();
    bus.reqValid = '0;
    bus.reqLast  = '0;
    #1;
    chk("ar_release", 32'(bus.grantValid), 0);
    chk("ar_rr_wrap", 32'(dbg_rr_ptr), 0);

    // requesters 0 and 1 each stream a 10-byte packet
`ifdef UART_ARB_BURST_LIMIT_EN
    exp_q     = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    exp_len_q = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd2, 8'd2};
`else
    exp_q     = '{8'd0, 8'd1};
    exp_len_q = '{8'd10, 8'd10};
`endif
    rem0 = 10;
    rem1 = 10;
    prev_gv = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (rem0 == 0 && rem1 == 0) break;
      bus.reqValid = {2'b00, rem1 > 0, rem0 > 0};
      bus.reqLast  = {2'b00, rem1 == 1, rem0 == 1};
      bus.reqData  = {16'h0000, 8'(8'h40 + 10 - rem1), 8'(10 - rem0)};
      #1;
      if (bus.grantValid && !prev_gv) begin
        got_id_q.push_back(8'(bus.grantId));
        got_len_q.push_back(8'd0);
      end
      prev_gv = bus.grantValid;
      if (bus.txValid && bus.txReady && got_len_q.size() > 0) begin
        got_len_q[got_len_q.size()-1] = got_len_q[got_len_q.size()-1] + 8'd1;
        if (bus.grantId == 2'd0) begin
          chk("st_data0", 32'(bus.txData), 32'(10 - rem0));
          rem0--;
        end else begin
          chk("st_data1", 32'(bus.txData), 32'(8'h40 + 10 - rem1));
          rem1--;
        end
      end
      tick();
    end
    bus.reqValid = '0;
    bus.reqLast  = '0;
    chk("st_done", 32'(rem0 + rem1), 0);
    chk("st_grants", 32'(got_id_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_id_q.size(); i++) begin
      chk("st_grant_id", 32'(got_id_q[i]), 32'(exp_q[i]));
      chk("st_grant_len", 32'(got_len_q[i]), 32'(exp_len_q[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit byte path among NumReq requesters using round-robin arbitration with packet locking.
- Each requester presents a valid/ready byte stream with a last marker. The arbiter holds its grant until the packet ends or the requester goes idle too long.
- Sits between the per-source TX FIFOs and the single UART transmitter/baud generator pair in the UART subsystem.

Parameters:
- NumReq, 4, number of requesters (2..16).
- IdleTimeout, 64, cycles a granted requester may hold reqValid low before its grant is revoked (>=2).
- MaxBurst, 16, maximum bytes per grant; used only when UART_ARB_BURST_LIMIT_EN is defined (>=1).
- IdWidth, $clog2(NumReq), derived; must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- syncReset  in  1  synchronous reset; same effect as nReset, applied on the clock edge.
- reqValid  in  NumReq  per-requester byte valid.
- reqLast  in  NumReq  per-requester last byte of packet; qualified by reqValid.
- reqData  in  NumReq x 8  packed per-requester byte; requester i uses bits [8i+7:8i].
- reqReady  out  NumReq  per-requester accept; one-hot or zero.
- txValid  out  1  byte valid toward transmitter.
- txData  out  8  byte toward transmitter.
- txReady  in  1  transmitter can accept a byte this cycle.
- grantValid  out  1  a requester currently owns the transmitter.
- grantId  out  IdWidth  index of the owning requester.
- timeoutErr  out  1  one-cycle pulse when a grant is revoked by idle timeout.

Behaviour:
- Reset, async on nReset low or sync on syncReset:
  - state=IDLE, rrPtr=0, grantId=0, grantValid=0, idleCnt=0, burstCnt=0, timeoutErr=0.
  - reqReady=0, txValid=0, txData=0.
  - Reset during LOCK drops the grant immediately. An in-flight unaccepted byte is not transferred.
- Transfer rule: a byte moves when txValid && txReady. reqReady[grantId]=txReady only in LOCK. All other reqReady bits are 0.
- Datapath in LOCK is combinational, zero added latency:
  - txValid=reqValid[grantId].
  - txData=reqData[grantId]. txData is 0 when not in LOCK.
- State IDLE:
  - If any reqValid is set, pick the first set bit searching upward from rrPtr with wrap (rrPtr, rrPtr+1, ..., NumReq-1, 0, ...).
  - Register the winner into grantId, set grantValid=1, go to LOCK.
  - Latency is 1 cycle from reqValid to the first possible transfer. No transfer occurs in IDLE.
- State LOCK:
  - Transfer with reqLast[grantId]=1: go to IDLE, rrPtr=(grantId+1) mod NumReq, grantValid=0 next cycle.
  - Idle counting: idleCnt increments each cycle reqValid[grantId]=0 and resets to 0 on any cycle it is 1.
  - Timeout: when idleCnt reaches IdleTimeout-1 with reqValid still low, go to IDLE, advance rrPtr as above, pulse timeoutErr for 1 cycle.
  - reqValid high with txReady low does not count as idle; backpressure never times out.
- Re-arbitration: one dead IDLE cycle follows every release, so minimum grant-to-grant spacing is 1 cycle.
- Fairness: after release, the releasing requester is lowest priority. With all requesters continuously active, grants rotate 0,1,2,...,NumReq-1,0.
- Widths: rrPtr and grantId are IdWidth bits, and wrap is explicit mod NumReq. For non-power-of-2 NumReq, index NumReq-1 wraps to 0. idleCnt and burstCnt are sized $clog2 of their limits plus 1.
- Simultaneous events:
  - Last-byte transfer and timeout cannot coincide, since a transfer implies valid high.
  - Under UART_ARB_BURST_LIMIT_EN, burst limit and reqLast on the same transfer is a normal release with no extra signalling.
- reqLast is ignored without reqValid. reqValid for non-granted requesters has no effect in LOCK.

Optional Feature:
- Macro: UART_ARB_BURST_LIMIT_EN.
- Defined:
  - burstCnt counts transfers in the current grant and clears on entering LOCK.
  - When a transfer makes burstCnt equal MaxBurst, release exactly as for reqLast: go to IDLE and advance rrPtr.
  - The requester's remaining bytes wait for a later grant; packets may be split.
- Undefined:
  - No burstCnt logic exists and MaxBurst is unused.
  - The grant is held until reqLast or timeout.

Test Plan:
- Reset, then reqValid=4'b0100 with a 3-byte packet A1,A2,A3 (last on A3), txReady=1 -> grantValid=1, grantId=2 one cycle later; txData A1,A2,A3 on consecutive cycles; grantValid=0 the cycle after A3; rrPtr=3.
- All four requesters continuously valid with 1-byte packets, txReady=1 -> grantId sequence 0,1,2,3,0, each separated by one IDLE cycle.
- Requester 1 granted, sends 1 byte without last, then drops reqValid, IdleTimeout=64 -> timeoutErr pulses once 64 cycles after reqValid falls; grant released; no byte lost or duplicated.
- Requester 0 granted, txReady=0 for 200 cycles with reqValid=1 -> no timeout; reqReady[0]=0 throughout; byte transfers once txReady=1.
- nReset asserted mid-packet on requester 3 -> all outputs return to reset values immediately; after release, requester 3 re-arbitrates from rrPtr=0.
- With UART_ARB_BURST_LIMIT_EN and MaxBurst=4, requesters 0 and 1 each stream a 10-byte packet -> grants alternate 0,1,0,1,0,1 carrying 4,4,4,4,2,2 bytes.
